// File: rtl/sd_wb_slave_ctrl.sv
// Wishbone slave controller for the SD host: decodes bus accesses to config regs, engine starts and data FIFO.
// Latency: regs/FIFO write/errors answer 1 cycle after decode, FIFO read 2 cycles, exec accesses after engine done/timeout.
// Backpressure: one ack or error per strobe; strobe must drop for a cycle before the next access is decoded.
module sd_wb_slave_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int REG_W          = 32
) (
  input  logic                  wb_clock,
  input  logic                  reset,
  input  logic                  strobe_i,
  input  logic                  we_i,
  input  logic [4:0]            adr_i,
  input  logic [127:0]          wb_data_i,
  output logic [127:0]          wb_data_o,
  output logic                  ack_o,
  output logic                  error_o,
  output logic [16*REG_W-1:0]   cfg_regs_o,
  output logic                  cmd_start_o,
  input  logic                  cmd_done_i,
  output logic                  data_start_o,
  input  logic                  data_done_i,
  output logic                  fifo_wr_en_o,
  output logic [127:0]          fifo_wr_data_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_rd_en_o,
  input  logic [127:0]          fifo_rd_data_i,
  input  logic                  fifo_empty_i
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD_WAIT, DATA_WAIT, FIFO_RD, RESP, HOLD} state_t;

  state_t           state_q, state_d;
  logic             resp_err_q, resp_err_d;
  logic             cmd_start_d, data_start_d, fifo_wr_d, fifo_rd_d;
  logic [15:0]      cnt_q;
  logic             cmd_done_flag_q, cmd_to_flag_q;
  logic             data_done_flag_q, data_to_flag_q;
  logic [REG_W-1:0] regs_q [16];
  logic             decode;

  // An access is decoded only from IDLE, so a held strobe cannot retrigger.
  assign decode  = (state_q == IDLE) && strobe_i;
  assign ack_o   = (state_q == RESP) && !resp_err_q;
  assign error_o = (state_q == RESP) && resp_err_q;

  // Flatten the register file onto the config bus.
  always_comb begin
    cfg_regs_o = '0;
    for (int k = 0; k < 16; k++) begin
      cfg_regs_o[k*REG_W +: REG_W] = regs_q[k];
    end
  end

  // Next-state logic and single-cycle pulse requests.
  always_comb begin
    state_d      = state_q;
    resp_err_d   = resp_err_q;
    cmd_start_d  = 1'b0;
    data_start_d = 1'b0;
    fifo_wr_d    = 1'b0;
    fifo_rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe_i) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
          if (!adr_i[4]) begin
            resp_err_d = 1'b0;
          end else begin
            case (adr_i)
              5'd16: begin
                if (we_i) begin
                  cmd_start_d = 1'b1;
                  state_d     = CMD_WAIT;
                end else begin
                  resp_err_d = 1'b0;
                end
              end
              5'd19: begin
                if (we_i) begin
                  data_start_d = 1'b1;
                  state_d      = DATA_WAIT;
                end else begin
                  resp_err_d = 1'b0;
                end
              end
              5'd17: begin
                if (we_i && !fifo_full_i) begin
                  fifo_wr_d  = 1'b1;
                  resp_err_d = 1'b0;
                end
              end
              5'd18: begin
                if (!we_i && !fifo_empty_i) begin
                  fifo_rd_d = 1'b1;
                  state_d   = FIFO_RD;
                end
              end
              default: ;
            endcase
          end
        end
      end
      CMD_WAIT: begin
        if (cmd_done_i) begin
          state_d    = RESP;
          resp_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end
      end
      DATA_WAIT: begin
        if (data_done_i) begin
          state_d    = RESP;
          resp_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end
      end
      FIFO_RD: begin
        state_d    = RESP;
        resp_err_d = 1'b0;
      end
      RESP:    state_d = HOLD;
      HOLD:    if (!strobe_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered one-cycle pulses.
  always_ff @(posedge wb_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_err_q   <= 1'b0;
      cmd_start_o  <= 1'b0;
      data_start_o <= 1'b0;
      fifo_wr_en_o <= 1'b0;
      fifo_rd_en_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_err_q   <= resp_err_d;
      cmd_start_o  <= cmd_start_d;
      data_start_o <= data_start_d;
      fifo_wr_en_o <= fifo_wr_d;
      fifo_rd_en_o <= fifo_rd_d;
    end
  end

  // Datapath: timeout counter, engine status flags, register file and read/write data.
  always_ff @(posedge wb_clock) begin
    if (reset) begin
      cnt_q            <= '0;
      cmd_done_flag_q  <= 1'b0;
      cmd_to_flag_q    <= 1'b0;
      data_done_flag_q <= 1'b0;
      data_to_flag_q   <= 1'b0;
      wb_data_o        <= '0;
      fifo_wr_data_o   <= '0;
      for (int k = 0; k < 16; k++) regs_q[k] <= '0;
    end else begin
      if ((state_q == CMD_WAIT || state_q == DATA_WAIT) && state_d == state_q)
        cnt_q <= cnt_q + 16'd1;
      else
        cnt_q <= '0;

      // Status of the last exec of each engine; done beats a same-cycle timeout.
      if (state_q == CMD_WAIT && state_d == RESP) begin
        cmd_done_flag_q <= cmd_done_i;
        cmd_to_flag_q   <= !cmd_done_i;
      end
      if (state_q == DATA_WAIT && state_d == RESP) begin
        data_done_flag_q <= data_done_i;
        data_to_flag_q   <= !data_done_i;
      end

      if (decode) fifo_wr_data_o <= wb_data_i;

      if (decode && we_i && !adr_i[4]) regs_q[adr_i[3:0]] <= wb_data_i[REG_W-1:0];

      if (decode && !we_i) begin
        if (!adr_i[4])
          wb_data_o <= {{(128-REG_W){1'b0}}, regs_q[adr_i[3:0]]};
        else if (adr_i == 5'd16)
          wb_data_o <= {126'b0, cmd_to_flag_q, cmd_done_flag_q};
        else if (adr_i == 5'd19)
          wb_data_o <= {126'b0, data_to_flag_q, data_done_flag_q};
      end else if (state_q == FIFO_RD) begin
        wb_data_o <= fifo_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sd_wb_slave_ctrl.sv
// Bench for sd_wb_slave_ctrl: table of bus accesses plus hand sequences for exec timeout, held strobe and reset abort.
// Responses are matched against a queue of expectations (kind, data, cycle) filled when each access is driven.
// Engine done pulses come from small responders keyed off the start pulses.
module tb_sd_wb_slave_ctrl;

  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           strobe, we;
  logic [4:0]     adr;
  logic [127:0]   wdat, rdat;
  logic           ack_o, error_o;
  logic [16*32-1:0] cfg_regs_o;
  logic           cmd_start_o, cmd_done_i, data_start_o, data_done_i;
  logic           fifo_wr_en_o, fifo_full, fifo_rd_en_o, fifo_empty;
  logic [127:0]   fifo_wr_data_o;
  logic [127:0]   fifo_rd_data;

  sd_wb_slave_ctrl #(.TIMEOUT_CYCLES(TO), .REG_W(32)) dut (
    .wb_clock(clk), .reset(reset), .strobe_i(strobe), .we_i(we), .adr_i(adr),
    .wb_data_i(wdat), .wb_data_o(rdat), .ack_o(ack_o), .error_o(error_o),
    .cfg_regs_o(cfg_regs_o), .cmd_start_o(cmd_start_o), .cmd_done_i(cmd_done_i),
    .data_start_o(data_start_o), .data_done_i(data_done_i),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_data_o(fifo_wr_data_o), .fifo_full_i(fifo_full),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data), .fifo_empty_i(fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [4:0]   adr;
    logic [127:0] dat;
    logic         full;
    logic         empty;
    int           cdly;
    int           ddly;
    logic         exp_err;
    logic         chk;
    logic [127:0] exp_dat;
    int           lat;
    int           n_cmd;
    int           n_dst;
    int           n_wr;
    int           n_rd;
  } vec_t;

  typedef struct {
    logic         err;
    logic         chk;
    logic [127:0] dat;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, drive_cyc = 0, resp_cnt = 0;
  int   p_cmd = 0, p_dst = 0, p_wr = 0, p_rd = 0;
  int   cmd_dly = -1, data_dly = -1;
  logic stray_go = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_o && error_o) check("ack_and_error", 1, 0);
      if (ack_o || error_o) begin
        resp_cnt++;
        if (q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_is_error", error_o, e.err);
          check("resp_cycle", cyc, e.due);
          if (e.chk) check("resp_data", rdat, e.dat);
        end
      end
      if (cmd_start_o)  begin p_cmd++; check("cmd_start_cycle", cyc, drive_cyc + 1); end
      if (data_start_o) begin p_dst++; check("data_start_cycle", cyc, drive_cyc + 1); end
      if (fifo_wr_en_o) begin
        p_wr++;
        check("fifo_wr_cycle", cyc, drive_cyc + 1);
        check("fifo_wr_data", fifo_wr_data_o, wdat);
      end
      if (fifo_rd_en_o) begin p_rd++; check("fifo_rd_cycle", cyc, drive_cyc + 1); end
    end
  end

  // Command engine model: done after cmd_dly cycles following a start (or a stray trigger).
  initial begin
    cmd_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if ((cmd_start_o || stray_go) && cmd_dly >= 0) begin
        repeat (cmd_dly) @(posedge clk);
        #1 cmd_done_i = 1'b1;
        @(posedge clk);
        #1 cmd_done_i = 1'b0;
      end
    end
  end

  // Data engine model: done after data_dly cycles following a start.
  initial begin
    data_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (data_start_o && data_dly >= 0) begin
        repeat (data_dly) @(posedge clk);
        #1 data_done_i = 1'b1;
        @(posedge clk);
        #1 data_done_i = 1'b0;
      end
    end
  end

  task automatic do_access(input vec_t v, input int hold);
    @(posedge clk);
    #1;
    strobe = 1'b1; we = v.we; adr = v.adr; wdat = v.dat;
    fifo_full = v.full; fifo_empty = v.empty;
    cmd_dly = v.cdly; data_dly = v.ddly;
    p_cmd = 0; p_dst = 0; p_wr = 0; p_rd = 0;
    drive_cyc = cyc;
    q.push_back('{err: v.exp_err, chk: v.chk, dat: v.exp_dat, due: cyc + v.lat});
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      check("resp_timeout", 0, 1);
      q.delete();
    end
    repeat (hold) @(posedge clk);
    #1 strobe = 1'b0;
    repeat (3) @(posedge clk);
    check("n_cmd_start", p_cmd, v.n_cmd);
    check("n_data_start", p_dst, v.n_dst);
    check("n_fifo_wr", p_wr, v.n_wr);
    check("n_fifo_rd", p_rd, v.n_rd);
  endtask

  vec_t vt[17];
  vec_t v;
  int   rc;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; strobe = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    fifo_full = 1'b0; fifo_empty = 1'b0; fifo_rd_data = 128'd9;

    //          we adr  dat                                    full empty cdly ddly err chk exp_dat        lat cmd dst wr rd
    vt[0]  = '{1, 5,  128'hCAFE0000_00000000_11111111_DEADBEEF, 0, 0, -1, -1, 0, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[1]  = '{0, 5,  128'd0,                                  0, 0, -1, -1, 0, 1, 128'hDEADBEEF,   1, 0, 0, 0, 0};
    vt[2]  = '{1, 15, 128'hFFFF0000_00000000_00000000_A5A50F0F, 0, 0, -1, -1, 0, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[3]  = '{0, 15, 128'd0,                                  0, 0, -1, -1, 0, 1, 128'hA5A50F0F,   1, 0, 0, 0, 0};
    vt[4]  = '{0, 0,  128'd0,                                  0, 0, -1, -1, 0, 1, 128'd0,          1, 0, 0, 0, 0};
    vt[5]  = '{0, 16, 128'd0,                                  0, 0, -1, -1, 0, 1, 128'd0,          1, 0, 0, 0, 0};
    vt[6]  = '{0, 19, 128'd0,                                  0, 0, -1, -1, 0, 1, 128'd0,          1, 0, 0, 0, 0};
    vt[7]  = '{1, 17, 128'd4,                                  0, 0, -1, -1, 0, 0, 128'd0,          1, 0, 0, 1, 0};
    vt[8]  = '{1, 17, 128'd7,                                  1, 0, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[9]  = '{0, 18, 128'd0,                                  0, 0, -1, -1, 0, 1, 128'd9,          2, 0, 0, 0, 1};
    vt[10] = '{0, 18, 128'd0,                                  0, 1, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[11] = '{0, 17, 128'd0,                                  0, 0, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[12] = '{1, 18, 128'd3,                                  0, 0, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[13] = '{1, 20, 128'd3,                                  0, 0, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[14] = '{0, 31, 128'd0,                                  0, 0, -1, -1, 1, 0, 128'd0,          1, 0, 0, 0, 0};
    vt[15] = '{1, 16, 128'd0,                                  0, 0, 10, -1, 0, 0, 128'd0,         12, 1, 0, 0, 0};
    vt[16] = '{0, 16, 128'd0,                                  0, 0, -1, -1, 0, 1, 128'd1,          1, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {ack_o, error_o, cmd_start_o, data_start_o, fifo_wr_en_o, fifo_rd_en_o}, 0);
    check("reset_wb_data", rdat, 0);
    check("reset_cfg", cfg_regs_o[127:0], 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_access(vt[i], 0);
      if (i == 0) check("cfg_reg5", cfg_regs_o[191:160], 32'hDEADBEEF);
    end
    check("cfg_reg15", cfg_regs_o[511:480], 32'hA5A50F0F);

    // Data exec with no done: timeout error; a stray command-engine done must not end it.
    v = '{1, 19, 128'd0, 0, 0, 2, -1, 1, 0, 128'd0, TO + 1, 0, 1, 0, 0};
    fork
      do_access(v, 0);
      begin
        repeat (4) @(posedge clk);
        #1 stray_go = 1'b1;
        @(posedge clk);
        #1 stray_go = 1'b0;
      end
    join
    v = '{0, 19, 128'd0, 0, 0, -1, -1, 0, 1, 128'd2, 1, 0, 0, 0, 0};
    do_access(v, 0);

    // Done arriving in the last counted cycle beats the timeout.
    v = '{1, 19, 128'd0, 0, 0, -1, TO - 1, 0, 0, 128'd0, TO + 1, 0, 1, 0, 0};
    do_access(v, 0);
    v = '{0, 19, 128'd0, 0, 0, -1, -1, 0, 1, 128'd1, 1, 0, 0, 0, 0};
    do_access(v, 0);

    // Strobe held for 20 cycles yields exactly one response.
    rc = resp_cnt;
    v = '{0, 5, 128'd0, 0, 0, -1, -1, 0, 1, 128'hDEADBEEF, 1, 0, 0, 0, 0};
    do_access(v, 20);
    check("held_strobe_resp_count", resp_cnt - rc, 1);

    // Reset while waiting on the command engine aborts silently.
    cmd_dly = -1;
    @(posedge clk);
    #1 strobe = 1'b1; we = 1'b1; adr = 5'd16; wdat = 128'h55;
    drive_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; strobe = 1'b0;
    rc = resp_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {ack_o, error_o, cmd_start_o, data_start_o, fifo_wr_en_o, fifo_rd_en_o}, 0);
    check("abort_wb_data", rdat, 0);
    check("abort_cfg_any", {127'd0, |cfg_regs_o}, 0);
    check("abort_fifo_wr_data", fifo_wr_data_o, 0);
    repeat (TO + 8) @(posedge clk);
    check("abort_no_resp", resp_cnt - rc, 0);
    v = '{0, 5, 128'd0, 0, 0, -1, -1, 0, 1, 128'd0, 1, 0, 0, 0, 0};
    do_access(v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_wb_slave_ctrl.md
Name: sd_wb_slave_ctrl

Overview:
Wishbone-side slave controller for the SD host. It decodes each strobed bus access on the 5-bit address map and sequences it: config register read/write, command-engine start, data-engine start, and data-FIFO push/pop. It returns one ack or error per access and waits for engine completion or timeout before responding to exec accesses. It sits between the Wishbone master and the command engine, data engine and host data FIFO.

Parameters:
TIMEOUT_CYCLES, 1024, maximum wb_clock cycles to wait for cmd_done_i / data_done_i; 16-bit counter.
REG_W, 32, width of each of the 16 config registers.

Ports:
wb_clock  input  1  bus and controller clock; rising edge.
reset  input  1  synchronous, active-high reset.
strobe_i  input  1  Wishbone strobe; access request.
we_i  input  1  1 = write, 0 = read.
adr_i  input  5  0-15 regs, 16 cmd exec, 17 FIFO write, 18 FIFO read, 19 data exec, 20-31 invalid.
wb_data_i  input  128  write data.
wb_data_o  output  128  read data; valid while ack_o = 1.
ack_o  output  1  access completed OK.
error_o  output  1  access failed.
cfg_regs_o  output  16*REG_W  flattened register file; reg k at bits [k*REG_W +: REG_W].
cmd_start_o  output  1  one-cycle start pulse to command engine.
cmd_done_i  input  1  command engine completion.
data_start_o  output  1  one-cycle start pulse to data engine.
data_done_i  input  1  data engine completion.
fifo_wr_en_o  output  1  one-cycle FIFO push.
fifo_wr_data_o  output  128  push data; equals wb_data_i latched at decode.
fifo_full_i  input  1  FIFO full.
fifo_rd_en_o  output  1  one-cycle FIFO pop.
fifo_rd_data_i  input  128  pop data, valid the cycle after fifo_rd_en_o.
fifo_empty_i  input  1  FIFO empty.

Behaviour:
- Reset value of every output and register is 0; the FSM goes to IDLE and the timeout counter clears. Reset during any state aborts the access with no ack and no error.
- FSM states: IDLE, CMD_WAIT, DATA_WAIT, FIFO_RD, RESP, HOLD.
- IDLE, strobe_i = 1 at edge N: latch adr_i, we_i and wb_data_i, then decode:
  - Reg write (0-15): reg[adr] <= wb_data_i[REG_W-1:0] at edge N. Go to RESP with ack.
  - Reg read (0-15): wb_data_o <= reg zero-extended. Go to RESP with ack.
  - 16 write: cmd_start_o = 1 for cycle N+1. Go to CMD_WAIT.
  - 19 write: data_start_o = 1 for cycle N+1. Go to DATA_WAIT.
  - 16 or 19 read: wb_data_o = {126'b0, timeout_flag, done_flag} from the last exec of that engine. RESP with ack.
  - 17 write: if fifo_full_i = 1, RESP with error and no push. Otherwise fifo_wr_en_o = 1 for one cycle, then RESP with ack.
  - 18 read: if fifo_empty_i = 1, RESP with error. Otherwise fifo_rd_en_o = 1 for one cycle, then FIFO_RD.
  - 17 read, 18 write, or adr 20-31: RESP with error.
- RESP: ack_o or error_o is high for exactly one cycle (cycle N+1 for single-cycle accesses). Then go to HOLD.
- HOLD: stay until strobe_i = 0, then go to IDLE. A new access needs strobe low for at least one cycle. A continuously held strobe never retriggers.
- FIFO_RD: wb_data_o <= fifo_rd_data_i. Ack in the next cycle, so ack arrives 2 cycles after decode.
- CMD_WAIT / DATA_WAIT:
  - Counter increments each cycle from 0.
  - Matching done_i = 1: set done_flag = 1, timeout_flag = 0, RESP with ack.
  - Counter reaching TIMEOUT_CYCLES-1 without done: set timeout_flag = 1, done_flag = 0, RESP with error.
  - Done and timeout in the same cycle: done wins.
  - Done pulses from the other engine are ignored.
- ack_o and error_o are never both high. The start and enable pulses are never high for more than one cycle per access.

Test Plan:
- Reset, then write adr 5 with data 0x...DEADBEEF, release strobe, read adr 5 -> ack 1 cycle after each strobe; read returns 0x0000...DEADBEEF; cfg_regs_o[191:160] = 0xDEADBEEF.
- Write adr 16; raise cmd_done_i 10 cycles after cmd_start_o -> single-cycle cmd_start_o; ack the cycle after done; read adr 16 returns 1.
- Write adr 19 with data_done_i never asserted, TIMEOUT_CYCLES = 8 -> error_o 8 cycles after data_start_o; read adr 19 returns 2.
- fifo_full_i = 1 then write adr 17 -> error, no fifo_wr_en_o. With fifo_full_i = 0 -> one push of wb_data_i = 4, then ack.
- Read adr 18 with fifo_rd_data_i = 9 -> fifo_rd_en_o at N+1, ack with wb_data_o = 9 at N+2. With fifo_empty_i = 1 -> error at N+1.
- Access adr 20 -> error. Holding strobe high for 20 cycles -> exactly one response. Reset asserted in CMD_WAIT -> no ack or error, and all outputs are 0 the next cycle.
